// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage feeding the control decoder. It owns the
// architectural PC and issues requests to a variable-latency instruction
// memory. It latches the returned word and presents it, with its PC, to
// decode/execute. When the instruction completes, it computes the next PC.
// A misaligned branch/jump target or an unanswered fetch stops the stage
// and raises a sticky fault; only rst clears the fault.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory side
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // decode/execute side
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        instr_done,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  // fault reporting
  output logic        fault,
  output logic [1:0]  fault_cause
);

  // NPC operation encodings; any other code behaves as PLUS4
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // fault cause encodings
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // last wait cycle before an unanswered request is declared dead
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_ISSUE = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  state_t            state_r;
  logic [31:0]       pc_r;
  logic [31:0]       pc_out_r;
  logic [31:0]       instr_r;
  logic              instr_valid_r;
  logic              fault_r;
  logic [1:0]        fault_cause_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [31:0]       next_pc_s;
  logic              misalign_s;

  // Next-PC selection. All arithmetic is 32-bit modulo and wraps silently.
  // JALR clears bit 0 of the target. Bit 1 is left alone, so a JALR can
  // still produce a misaligned target.
  function automatic logic [31:0] calc_next_pc(
    input logic [2:0]  op,
    input logic [31:0] pc,
    input logic [31:0] offset,
    input logic [31:0] rs1
  );
    logic [31:0] target;
    case (op)
      NPC_PLUS4:  target = pc + 32'd4;
      NPC_BRANCH: target = pc + offset;
      NPC_JUMP:   target = pc + offset;
      NPC_JALR:   target = (rs1 + offset) & 32'hFFFF_FFFE;
      default:    target = pc + 32'd4;
    endcase
    return target;
  endfunction

  // A fetch target is usable only when it is word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Target of the instruction currently in S_ISSUE, and whether it is legal.
  always_comb begin
    next_pc_s  = calc_next_pc(npc_op, pc_r, imm, rs1_val);
    misalign_s = is_misaligned(next_pc_s);
  end

  // Fetch/issue/fault sequencer. It also owns the PC, the instruction latch,
  // the timeout counter and the sticky fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_FETCH;
      pc_r          <= RESET_PC;
      pc_out_r      <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
      fault_cause_r <= CAUSE_NONE;
      cnt_r         <= CNT_ZERO;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_ack) begin
            // Zero-wait memory lands here on the first request cycle.
            instr_r       <= imem_rdata;
            pc_out_r      <= pc_r;
            instr_valid_r <= 1'b1;
            cnt_r         <= CNT_ZERO;
            state_r       <= S_ISSUE;
          end else if (cnt_r == CNT_LAST) begin
            // The request went unanswered for TIMEOUT cycles. pc keeps the
            // address that was never answered, for post-mortem.
            fault_r       <= 1'b1;
            fault_cause_r <= CAUSE_TIMEOUT;
            instr_valid_r <= 1'b0;
            state_r       <= S_FAULT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        S_ISSUE: begin
          if (instr_done) begin
            pc_r          <= next_pc_s;
            instr_valid_r <= 1'b0;
            cnt_r         <= CNT_ZERO;
            if (misalign_s) begin
              // Park on the bad target without ever requesting it.
              fault_r       <= 1'b1;
              fault_cause_r <= CAUSE_MISALIGN;
              state_r       <= S_FAULT;
            end else begin
              state_r <= S_FETCH;
            end
          end else begin
            instr_valid_r <= 1'b1;
          end
        end

        S_FAULT: begin
          // Terminal until reset. ack and done are deliberately ignored.
          instr_valid_r <= 1'b0;
          fault_r       <= 1'b1;
        end

        default: begin
          // Unreachable encoding: drop any instruction and refetch from pc.
          instr_valid_r <= 1'b0;
          cnt_r         <= CNT_ZERO;
          state_r       <= S_FETCH;
        end
      endcase
    end
  end

  // The request is a pure decode of state so that a zero-wait memory can
  // answer in the first cycle. A reset cycle suppresses it at once.
  always_comb begin
    imem_req = (state_r == S_FETCH) && !rst;
  end

  // Remaining outputs are straight from registers.
  always_comb begin
    imem_addr   = pc_r;
    instr_valid = instr_valid_r;
    instr       = instr_r;
    pc_out      = pc_out_r;
    fault       = fault_r;
    fault_cause = fault_cause_r;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed, self-checking bench for if_fetch_unit. Inputs change 1 time unit
// after each rising edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_done;
  logic [2:0]  npc_op;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_done  (instr_done),
    .npc_op      (npc_op),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("req_in_rst", {31'd0, imem_req}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Serve one fetch at addr with the given number of wait cycles before ack.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    chk("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, addr);
      chk("wait_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_instr", instr, data);
    chk("issue_pc", pc_out, addr);
    chk("issue_req_low", {31'd0, imem_req}, 32'd0);
  endtask

  // Complete the issued instruction with the given next-PC controls.
  task automatic complete(input logic [2:0] op, input logic [31:0] im, input logic [31:0] rs1);
    instr_done = 1'b1;
    npc_op     = op;
    imm        = im;
    rs1_val    = rs1;
    step();
    instr_done = 1'b0;
    npc_op     = 3'b000;
    imm        = 32'h0000_0000;
    rs1_val    = 32'h0000_0000;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    instr_done = 1'b0;
    npc_op     = 3'b000;
    imm        = 32'h0000_0000;
    rs1_val    = 32'h0000_0000;
    step();
    step();

    // reset state
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_cause", {30'd0, fault_cause}, 32'd0);
    rst = 1'b0;
    #1;

    // T1: zero-wait fetch right after reset
    fetch(32'h0000_0000, 32'h0050_0093, 0);

    // T2: PLUS4 chain with 2-cycle ack latency
    complete(3'b000, 32'h0, 32'h0);
    fetch(32'h0000_0004, 32'h1111_0001, 1);
    complete(3'b000, 32'h0, 32'h0);
    fetch(32'h0000_0008, 32'h2222_0002, 1);
    complete(3'b000, 32'h0, 32'h0);
    fetch(32'h0000_000C, 32'h3333_0003, 1);
    // unused code behaves as PLUS4
    complete(3'b111, 32'h0000_0040, 32'h0);
    fetch(32'h0000_0010, 32'h4444_0004, 0);

    // T3: BRANCH back by 8, then JUMP forward by 0x100
    complete(3'b001, 32'hFFFF_FFF8, 32'h0);
    fetch(32'h0000_0008, 32'h5555_0005, 0);
    complete(3'b000, 32'h0, 32'h0);
    fetch(32'h0000_000C, 32'h6666_0006, 0);
    complete(3'b000, 32'h0, 32'h0);
    fetch(32'h0000_0010, 32'h7777_0007, 0);
    complete(3'b010, 32'h0000_0100, 32'h0);
    fetch(32'h0000_0110, 32'h8888_0008, 0);

    // T4: JALR targets, bit 0 cleared, then a bit-1 misalignment
    complete(3'b100, 32'h0000_0003, 32'h0000_1001);
    fetch(32'h0000_1004, 32'h9999_0009, 0);
    complete(3'b100, 32'h0000_0005, 32'h0000_1000);
    fetch(32'h0000_1004, 32'hAAAA_000A, 0);
    complete(3'b100, 32'h0000_0002, 32'h0000_1000);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_cause", {30'd0, fault_cause}, 32'd1);
    chk("mis_pc", imem_addr, 32'h0000_1002);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    instr_done = 1'b1;
    step();
    step();
    imem_ack   = 1'b0;
    instr_done = 1'b0;
    chk("mis_stuck_cause", {30'd0, fault_cause}, 32'd1);
    chk("mis_stuck_pc", imem_addr, 32'h0000_1002);
    chk("mis_stuck_req", {31'd0, imem_req}, 32'd0);

    // PC wrap from 0xFFFF_FFFC to 0 is not a fault
    do_reset();
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_cause", {30'd0, fault_cause}, 32'd0);
    fetch(32'h0000_0000, 32'hBBBB_000B, 0);
    complete(3'b010, 32'hFFFF_FFFC, 32'h0);
    fetch(32'hFFFF_FFFC, 32'hCCCC_000C, 0);
    complete(3'b000, 32'h0, 32'h0);
    chk("wrap_fault", {31'd0, fault}, 32'd0);
    fetch(32'h0000_0000, 32'hDDDD_000D, 0);

    // T5: no ack for TIMEOUT cycles at address 4
    complete(3'b000, 32'h0, 32'h0);
    chk("to_start_addr", imem_addr, 32'h0000_0004);
    for (int i = 0; i < 15; i++) step();
    chk("to_still_req", {31'd0, imem_req}, 32'd1);
    chk("to_no_fault_yet", {31'd0, fault}, 32'd0);
    step();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_cause", {30'd0, fault_cause}, 32'd2);
    chk("to_pc", imem_addr, 32'h0000_0004);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hEEEE_EEEE;
    instr_done = 1'b1;
    step();
    step();
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    instr_done = 1'b0;
    chk("to_late_valid", {31'd0, instr_valid}, 32'd0);
    chk("to_late_instr", instr, 32'hDDDD_000D);
    chk("to_late_pc", imem_addr, 32'h0000_0004);
    chk("to_late_cause", {30'd0, fault_cause}, 32'd2);

    // T6: reset while waiting at 0x20, with an ack in the reset cycle
    do_reset();
    chk("t6_clr_fault", {31'd0, fault}, 32'd0);
    fetch(32'h0000_0000, 32'h1234_5678, 0);
    complete(3'b010, 32'h0000_0020, 32'h0);
    chk("t6_addr", imem_addr, 32'h0000_0020);
    step();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_req_drop", {31'd0, imem_req}, 32'd0);
    step();
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    #1;
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_instr", instr, 32'h0000_0000);
    chk("t6_addr_rst", imem_addr, 32'h0000_0000);
    chk("t6_fault", {31'd0, fault}, 32'd0);
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0000_0000, 32'h0050_0093, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
